decode_issue_queue: RTL and testbench

- Sits directly downstream of the decode unit's stage-3 mux; consumes its per-instruction output group and buffers it for the issue/dispatch stage.
- Circular FIFO of fully decoded instructions, first-word-fall-through on the read side.
- Drives a registered stall back to the decode unit so that its three in-flight stages always have room to drain.
- Provides a flush for mispredict or exception recovery, and a sticky overflow flag for verification.

---
 rtl/decode_issue_queue.sv | 165 ++++++++++++++++
 tb/tb_decode_issue_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// -----------------------------------------------------------------------------
// decode_issue_queue
//
// Buffers fully decoded instructions between the decode unit's stage-3 mux and
// the issue/dispatch stage. It is a circular FIFO, and the read side is
// first-word-fall-through.
//
// A registered stall is driven back to decode. It asserts early enough that
// the three decode stages already in flight can always drain into the queue.
//
// Ports
//   clock_i, reset_i     clock; synchronous active-high reset
//   flush_i              discard every entry (mispredict / exception recovery)
//   enable_i + fields    one decoded instruction offered this cycle
//   dequeue_i            issue stage consumes the head entry
//   valid_o + fields     head entry; fields read 0 while valid_o is low
//   stall_o              registered back-pressure to decode
//   count_o              occupancy, 0..queueDepth
//   overflow_o           sticky: an instruction was dropped while full
//
// Handshake: the write side has no ready. Decode must honour stall_o, and an
// enable_i that arrives while the queue is full (and nothing is dequeued) is
// dropped and flagged on overflow_o. On the read side, valid_o acts as the
// valid and dequeue_i acts as the ready. The head entry is consumed on a clock
// edge only when both are high.
// -----------------------------------------------------------------------------
module decode_issue_queue #(
    parameter int queueDepth              = 8,
    parameter int queueIndexWidth         = 3,
    parameter int skidSlots               = 4,
    parameter int opcodeSize              = 12,
    parameter int addressWidth            = 64,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int bodySize                = 84
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            address_i,
    input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] majID_i,
    input  logic [instMinIdWidth-1:0]          minID_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic [regAccessPatternSize-1:0]    op3rw_i,
    input  logic [regAccessPatternSize-1:0]    op4rw_i,
    input  logic                               op1IsReg_i,
    input  logic                               op2IsReg_i,
    input  logic                               op3IsReg_i,
    input  logic                               op4IsReg_i,
    input  logic [bodySize-1:0]                body_i,
    input  logic                               dequeue_i,
    output logic                               valid_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            address_o,
    output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
    output logic [instructionCounterWidth-1:0] majID_o,
    output logic [instMinIdWidth-1:0]          minID_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic [regAccessPatternSize-1:0]    op3rw_o,
    output logic [regAccessPatternSize-1:0]    op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic [bodySize-1:0]                body_o,
    output logic                               stall_o,
    output logic [queueIndexWidth:0]           count_o,
    output logic                               overflow_o
);

    localparam int entryWidth = opcodeSize + addressWidth + funcUnitCodeSize
                              + instructionCounterWidth + instMinIdWidth + 1
                              + PidSize + TidSize + 4 * regAccessPatternSize
                              + 4 + bodySize;
    localparam int countWidth = queueIndexWidth + 1;

    localparam logic [countWidth-1:0] fullLevel  = countWidth'(queueDepth);
    localparam logic [countWidth-1:0] stallLevel = countWidth'(queueDepth - skidSlots);

    logic [entryWidth-1:0]      storage [queueDepth];
    logic [queueIndexWidth-1:0] headPtr;
    logic [queueIndexWidth-1:0] tailPtr;
    logic [countWidth-1:0]      countQ;
    logic                       stallQ;
    logic                       overflowQ;

    logic                  isFull;
    logic                  doDequeue;
    logic                  doEnqueue;
    logic                  dropEnqueue;
    logic [countWidth-1:0] countNext;
    logic [entryWidth-1:0] entryIn;
    logic [entryWidth-1:0] headEntry;

    // The field order here must match the unpacking of headEntry below.
    assign entryIn = {opcode_i, address_i, funcUnitType_i, majID_i, minID_i,
                      is64Bit_i, pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i,
                      op4rw_i, op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i,
                      body_i};

    assign isFull    = (countQ == fullLevel);
    assign valid_o   = (countQ != '0);
    assign doDequeue = dequeue_i && valid_o;
    // When the queue is full, a same-cycle dequeue frees the slot being
    // written. The tail then catches up to the head, which is being released.
    assign doEnqueue   = enable_i && (!isFull || doDequeue);
    assign dropEnqueue = enable_i && isFull && !doDequeue;
    assign countNext   = countQ + countWidth'(doEnqueue) - countWidth'(doDequeue);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            countQ    <= '0;
            stallQ    <= 1'b0;
            overflowQ <= 1'b0;
        end else if (flush_i) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
            stallQ  <= 1'b0;
        end else begin
            if (doEnqueue) tailPtr <= tailPtr + 1'b1;
            if (doDequeue) headPtr <= headPtr + 1'b1;
            countQ <= countNext;
            // The threshold is applied to the post-update count. This means
            // the stall register already reflects the occupancy that decode
            // will observe one cycle later.
            stallQ <= (countNext >= stallLevel);
            if (dropEnqueue) overflowQ <= 1'b1;
        end
    end

    // The storage array has no reset because its contents do not matter
    // while they are outside the head..tail window.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !flush_i && doEnqueue) storage[tailPtr] <= entryIn;
    end

    assign headEntry = valid_o ? storage[headPtr] : '0;

    assign {opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
            is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
            op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o} = headEntry;

    assign stall_o    = stallQ;
    assign count_o    = countQ;
    assign overflow_o = overflowQ;

endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;

  localparam int EW = 12 + 64 + 3 + 64 + 7 + 1 + 20 + 16 + 8 + 4 + 84;

  logic clock_i = 1'b0;
  logic reset_i, flush_i, enable_i, dequeue_i;
  logic [11:0] opcode_i;
  logic [63:0] address_i;
  logic [2:0] funcUnitType_i;
  logic [63:0] majID_i;
  logic [6:0] minID_i;
  logic is64Bit_i;
  logic [19:0] pid_i;
  logic [15:0] tid_i;
  logic [1:0] op1rw_i, op2rw_i, op3rw_i, op4rw_i;
  logic op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
  logic [83:0] body_i;

  logic valid_o;
  logic [11:0] opcode_o;
  logic [63:0] address_o;
  logic [2:0] funcUnitType_o;
  logic [63:0] majID_o;
  logic [6:0] minID_o;
  logic is64Bit_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;
  logic [1:0] op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic [83:0] body_o;
  logic stall_o;
  logic [3:0] count_o;
  logic overflow_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];

  decode_issue_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
    .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(funcUnitType_i),
    .majID_i(majID_i), .minID_i(minID_i), .is64Bit_i(is64Bit_i), .pid_i(pid_i),
    .tid_i(tid_i), .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i),
    .op4rw_i(op4rw_i), .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i),
    .op3IsReg_i(op3IsReg_i), .op4IsReg_i(op4IsReg_i), .body_i(body_i),
    .dequeue_i(dequeue_i), .valid_o(valid_o), .opcode_o(opcode_o),
    .address_o(address_o), .funcUnitType_o(funcUnitType_o), .majID_o(majID_o),
    .minID_o(minID_o), .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o),
    .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
    .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o),
    .op4IsReg_o(op4IsReg_o), .body_o(body_o), .stall_o(stall_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  // clock / reset block
  always #5 clock_i = ~clock_i;

  // every field is derived from the id so that a swapped or corrupted field is visible
  function automatic logic [EW-1:0] make_entry(input logic [63:0] id);
    logic [83:0] body_base;
    body_base = 84'h5A5A5A5A5A5A5A5A5A5A5;
    return {id[11:0] ^ 12'hA5C, {id[31:0], ~id[31:0]}, id[2:0], id,
            id[6:0] + 7'd3, id[0], id[19:0] ^ 20'h12345, id[15:0] ^ 16'hBEEF,
            id[1:0], ~id[1:0], 2'b11, id[2:1], id[3:0], body_base ^ {20'd0, id}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present one cycle of stimulus, wait for the edge, return 1 ns after it
  task automatic step(input logic en, input logic [63:0] id, input logic deq,
                      input logic fl, input logic rst, input logic acc);
    enable_i  = en;
    dequeue_i = deq;
    flush_i   = fl;
    reset_i   = rst;
    {opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i, pid_i,
     tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i, op1IsReg_i, op2IsReg_i,
     op3IsReg_i, op4IsReg_i, body_i} = en ? make_entry(id) : '0;
    if (acc) exp_q.push_back(make_entry(id));
    @(posedge clock_i);
    #1;
    if (fl || rst) exp_q.delete();
  endtask

  task automatic enq(input logic [63:0] id);
    step(1'b1, id, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic deq();
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: whenever the DUT hands over its head entry, compare it to the scoreboard
  always @(negedge clock_i) begin
    if (dequeue_i === 1'b1 && valid_o === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pop_unexpected: got majID %0d, expected nothing", majID_o);
      end else begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        act = {opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
               pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o, op1IsReg_o,
               op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o};
        exp = exp_q.pop_front();
        if (act !== exp) begin
          tests_failed++;
          $display("FAIL entry: got %h expected %h", act, exp);
        end
      end
    end
  end

  initial begin
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("reset_valid", valid_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_stall", stall_o, 0);
    chk("reset_overflow", overflow_o, 0);
    chk("reset_opcode", opcode_o, 0);
    chk("reset_majID", majID_o, 0);
    chk("reset_body_lo", body_o[63:0], 0);

    // stall threshold at count 4
    for (int i = 1; i <= 3; i++) enq(i);
    chk("fill3_count", count_o, 3);
    chk("fill3_valid", valid_o, 1);
    chk("fill3_head", majID_o, 1);
    chk("fill3_stall", stall_o, 0);
    enq(4);
    chk("fill4_count", count_o, 4);
    chk("fill4_stall", stall_o, 1);
    deq();
    chk("deq1_head", majID_o, 2);
    chk("deq1_count", count_o, 3);
    chk("deq1_stall", stall_o, 0);
    for (int i = 0; i < 3; i++) deq();
    chk("drain1_count", count_o, 0);
    chk("drain1_valid", valid_o, 0);

    // full drop sets the sticky overflow flag
    for (int i = 10; i <= 17; i++) enq(i);
    chk("full_count", count_o, 8);
    chk("full_stall", stall_o, 1);
    chk("full_overflow_clear", overflow_o, 0);
    step(1'b1, 64'd18, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_count", count_o, 8);
    chk("drop_overflow", overflow_o, 1);
    for (int i = 0; i < 8; i++) deq();
    chk("drain2_count", count_o, 0);
    chk("drain2_overflow_sticky", overflow_o, 1);
    chk("drain2_stall", stall_o, 0);
    chk("drain2_sb_empty", exp_q.size(), 0);

    // full with a coincident enqueue and dequeue
    for (int i = 20; i <= 27; i++) enq(i);
    step(1'b1, 64'd30, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fulldeq_count", count_o, 8);
    chk("fulldeq_head", majID_o, 21);
    for (int i = 0; i < 8; i++) deq();
    chk("drain3_count", count_o, 0);
    chk("drain3_sb_empty", exp_q.size(), 0);

    // streaming at count 2 across the pointer wrap
    enq(40);
    enq(41);
    for (int i = 0; i < 20; i++) step(1'b1, 64'd42 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stream_count", count_o, 2);
    chk("stream_head", majID_o, 60);
    chk("stream_op3rw", op3rw_o, 2'b11);
    chk("stream_stall", stall_o, 0);
    deq();
    deq();
    chk("drain4_sb_empty", exp_q.size(), 0);

    // empty: simultaneous enqueue and dequeue is not a bypass
    step(1'b1, 64'd90, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("nobypass_count", count_o, 1);
    chk("nobypass_head", majID_o, 90);
    deq();
    chk("nobypass_drain", count_o, 0);

    // flush at count 5 with a coincident enqueue
    for (int i = 60; i <= 64; i++) enq(i);
    chk("preflush_stall", stall_o, 1);
    step(1'b1, 64'd65, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_count", count_o, 0);
    chk("flush_valid", valid_o, 0);
    chk("flush_stall", stall_o, 0);
    chk("flush_overflow_kept", overflow_o, 1);
    idle();
    chk("flush_entry_absent", count_o, 0);

    // reset at count 6 with a dequeue
    for (int i = 70; i <= 75; i++) enq(i);
    chk("prereset_count", count_o, 6);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("midreset_count", count_o, 0);
    chk("midreset_overflow", overflow_o, 0);
    chk("midreset_valid", valid_o, 0);
    chk("midreset_stall", stall_o, 0);

    // normal operation after a mid-operation reset
    enq(80);
    chk("postreset_head", majID_o, 80);
    deq();
    idle();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
